fetch_sequencer: RTL and testbench

- Fetch-stage controller for the pipelined MIPS core.
- Owns the PC register and computes next-PC: sequential PC+4, branch, j/jal and jr targets. The delay-slot rule is honoured.
- Runs a req/ack handshake with a variable-latency instruction memory.
- Presents fetched instructions to the F/D register through a one-entry output buffer, and holds that buffer under hazard stall.

---
 rtl/fetch_sequencer_if.sv | 22 ++
 rtl/fetch_sequencer.sv | 156 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and imem.
// The master holds addr stable from the first req cycle until ack.
interface fetch_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, computes next-PC with delay-slot semantics,
// runs the imem req/ack handshake and feeds F/D through a one-entry buffer.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_f,
  input  logic              redir_valid,
  input  logic [2:0]        redir_op,
  input  logic [31:0]       redir_base,
  input  logic [31:0]       redir_instr,
  input  logic [31:0]       redir_ra,
  fetch_sequencer_if.master imem,
  output logic              f_valid,
  output logic [31:0]       f_pc,
  output logic [31:0]       f_instr
);

  typedef enum logic [1:0] {StBoot, StReq, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pend_valid_q, pend_valid_d;
  logic        kill_q, kill_d;
  logic        issued_q;
  logic [31:0] addr_q;
  logic        f_valid_q;
  logic [31:0] f_pc_q, f_instr_q;

  logic [31:0] redir_tgt;
  logic        redir_legal, redir_pre, redir_post;
  logic        consume, room, ack_seen, capture;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^redir_instr[31:26];

  always_comb begin
    redir_tgt = redir_ra;
    case (redir_op)
      3'b001:  redir_tgt = redir_base + {{14{redir_instr[15]}}, redir_instr[15:0], 2'b00};
      3'b010:  redir_tgt = {redir_base[31:28], redir_instr[25:0], 2'b00};
      default: redir_tgt = redir_ra;
    endcase
  end

  assign redir_legal = redir_valid & ~redir_op[2] & (redir_op[1:0] != 2'b00);
  // pc_q still at the delay slot means the slot is not yet captured: defer the target.
  assign redir_pre   = redir_legal & (pc_q == redir_base);
  assign redir_post  = redir_legal & ~redir_pre;

  assign consume  = f_valid_q & ~stall_f;
  assign room     = ~f_valid_q | ~stall_f;
  assign ack_seen = imem.req & imem.ack;
  // An ack that finds no room is dropped and the same pc_q is fetched again.
  assign capture  = ack_seen & ~kill_q & ~redir_post & room;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StBoot: state_d = StReq;
      StReq: begin
        if (capture) begin
          state_d = stall_f ? StHold : StReq;
        end
      end
      StHold: begin
        if (consume) begin
          state_d = StReq;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // Outputs: a new request is only raised when the buffer can take the word,
  // but once raised it is held (with its latched address) until ack.
  always_comb begin
    imem.req  = 1'b0;
    imem.addr = issued_q ? addr_q : pc_q;
    if (state_q == StReq) begin
      imem.req = issued_q | room;
    end
  end

  always_comb begin
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
    kill_d       = kill_q;
    if (ack_seen) begin
      kill_d = 1'b0;
    end
    if (redir_pre) begin
      pend_valid_d = 1'b1;
      pend_tgt_d   = redir_tgt;
    end
    if (capture) begin
      pc_d         = redir_pre ? redir_tgt : (pend_valid_q ? pend_tgt_q : pc_q + 32'd4);
      pend_valid_d = 1'b0;
    end
    if (redir_post) begin
      pc_d         = redir_tgt;
      pend_valid_d = 1'b0;
      if (imem.req && !imem.ack) begin
        kill_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= RESET_PC;
      kill_q       <= 1'b0;
      issued_q     <= 1'b0;
      addr_q       <= RESET_PC;
      f_valid_q    <= 1'b0;
      f_pc_q       <= RESET_PC;
      f_instr_q    <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
      kill_q       <= kill_d;
      issued_q     <= imem.req & ~imem.ack;
      if (imem.req) begin
        addr_q <= imem.addr;
      end
      if (capture) begin
        f_valid_q <= 1'b1;
        f_pc_q    <= imem.addr;
        f_instr_q <= imem.rdata;
      end else if (consume) begin
        f_valid_q <= 1'b0;
      end
    end
  end

  assign f_valid = f_valid_q;
  assign f_pc    = f_pc_q;
  assign f_instr = f_instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes expected acked addresses and
// consumed instructions; a monitor pops and compares them as the DUT produces them.
module tb_fetch_sequencer;
  localparam logic [31:0] ResetPc = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_f = 1'b0;
  logic        redir_valid = 1'b0;
  logic [2:0]  redir_op = 3'b000;
  logic [31:0] redir_base = 32'h0;
  logic [31:0] redir_instr = 32'h0;
  logic [31:0] redir_ra = 32'h0;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;

  int unsigned lat = 0;
  int unsigned cnt = 0;
  logic        stray_ack = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] exp_fetch[$];
  logic [31:0] exp_ack[$];

  fetch_sequencer_if imem_bus ();

  fetch_sequencer #(.RESET_PC(ResetPc)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall_f    (stall_f),
    .redir_valid(redir_valid),
    .redir_op   (redir_op),
    .redir_base (redir_base),
    .redir_instr(redir_instr),
    .redir_ra   (redir_ra),
    .imem       (imem_bus),
    .f_valid    (f_valid),
    .f_pc       (f_pc),
    .f_instr    (f_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  // Variable-latency memory: ack after lat cycles of req; stray_ack injects a bogus strobe.
  always @(posedge clk) begin
    if (imem_bus.req && !imem_bus.ack) cnt <= cnt + 1;
    else cnt <= 0;
  end
  assign imem_bus.ack   = (imem_bus.req && (cnt == lat)) || stray_ack;
  assign imem_bus.rdata = stray_ack ? 32'hBAD0_BAD0 : mem_word(imem_bus.addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples just before each rising edge.
  logic [31:0] prev_addr = 32'h0;
  logic        prev_open = 1'b0;
  logic [31:0] mon_pc;
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!reset) begin
        prev_open = 1'b0;
      end else begin
        if (prev_open) begin
          check("req_held", {31'h0, imem_bus.req}, 32'h1);
          check("addr_stable", imem_bus.addr, prev_addr);
        end
        prev_open = imem_bus.req && !imem_bus.ack;
        prev_addr = imem_bus.addr;
        if (imem_bus.req && imem_bus.ack && exp_ack.size() > 0) begin
          check("ack_addr", imem_bus.addr, exp_ack.pop_front());
        end
        if (f_valid && !stall_f && exp_fetch.size() > 0) begin
          mon_pc = exp_fetch.pop_front();
          check("f_pc", f_pc, mon_pc);
          check("f_instr", f_instr, mem_word(mon_pc));
        end
      end
    end
  end

  task automatic start(input int unsigned l);
    reset       = 1'b0;
    stall_f     = 1'b0;
    redir_valid = 1'b0;
    stray_ack   = 1'b0;
    lat         = l;
    exp_fetch.delete();
    exp_ack.delete();
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic expect_seq(input logic [31:0] pcs[$], input logic [31:0] acks[$]);
    foreach (pcs[i]) exp_fetch.push_back(pcs[i]);
    foreach (acks[i]) exp_ack.push_back(acks[i]);
  endtask

  task automatic wait_show(input logic [31:0] pc);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!(f_valid && f_pc == pc) && i < 200);
    if (i >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_show: f_pc %h never presented, required %h", f_pc, pc);
    end
  endtask

  task automatic redirect(input logic [2:0] op, input logic [31:0] base,
                          input logic [31:0] instr, input logic [31:0] ra);
    #1;
    redir_valid = 1'b1;
    redir_op    = op;
    redir_base  = base;
    redir_instr = instr;
    redir_ra    = ra;
    @(negedge clk);
    #1;
    redir_valid = 1'b0;
    redir_op    = 3'b000;
  endtask

  task automatic drain(input string name);
    int i = 0;
    while ((exp_fetch.size() > 0 || exp_ack.size() > 0) && i < 300) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    n_checks++;
    if (exp_fetch.size() + exp_ack.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: %0d expectations left, required 0", name,
               exp_fetch.size() + exp_ack.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and sequential fetch, zero-wait; an illegal redirect op is ignored.
    start(0);
    expect_seq('{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3014},
               '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3014});
    #2;
    check("boot_req", {31'h0, imem_bus.req}, 32'h0);
    check("boot_f_pc", f_pc, ResetPc);
    check("boot_f_instr", f_instr, 32'h0);
    @(negedge clk); #4;
    check("c1_req", {31'h0, imem_bus.req}, 32'h1);
    check("c1_addr", imem_bus.addr, 32'h3000);
    check("c1_f_valid", {31'h0, f_valid}, 32'h0);
    @(negedge clk); #4;
    check("c2_addr", imem_bus.addr, 32'h3004);
    check("c2_f_pc", f_pc, 32'h3000);
    @(negedge clk); #4;
    check("c3_addr", imem_bus.addr, 32'h3008);
    check("c3_f_pc", f_pc, 32'h3004);
    @(negedge clk);
    redirect(3'b111, 32'h3008, 32'h03E0_0008, 32'h0000_5000);
    drain("seq");

    // Stall hold with the buffer showing 0x3004.
    start(0);
    expect_seq('{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010},
               '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010});
    wait_show(32'h3004);
    #1 stall_f = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("stall_f_pc", f_pc, 32'h3004);
      check("stall_f_instr", f_instr, mem_word(32'h3004));
      check("stall_req", {31'h0, imem_bus.req}, 32'h0);
      @(negedge clk);
      #1;
    end
    stall_f = 1'b0;
    drain("stall");

    // Branch before the delay slot is fetched: beq imm -2 from base 0x3008.
    start(3);
    expect_seq('{32'h3000, 32'h3004, 32'h3008, 32'h3000, 32'h3004},
               '{32'h3000, 32'h3004, 32'h3008, 32'h3000, 32'h3004});
    wait_show(32'h3004);
    redirect(3'b001, 32'h3008, 32'h1000_FFFE, 32'h0);
    drain("branch_pre");

    // Jump after the delay slot is captured with 0x300C outstanding: killed.
    start(3);
    expect_seq('{32'h3000, 32'h3004, 32'h3008, 32'h3100, 32'h3104},
               '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3100, 32'h3104});
    wait_show(32'h3008);
    redirect(3'b010, 32'h3008, 32'h0800_0C40, 32'h0);
    drain("jump_kill");

    // jr with the ack for base+4 in the same cycle: word dropped.
    start(0);
    expect_seq('{32'h3000, 32'h3004, 32'h3ABC, 32'h3AC0},
               '{32'h3000, 32'h3004, 32'h3008, 32'h3ABC, 32'h3AC0});
    wait_show(32'h3004);
    redirect(3'b011, 32'h3004, 32'h03E0_0008, 32'h0000_3ABC);
    drain("jr_same_ack");

    // Reset mid-fetch, stray acks during reset and in BOOT.
    start(3);
    wait_show(32'h3004);
    #1 reset = 1'b0;
    #2;
    check("rst_req", {31'h0, imem_bus.req}, 32'h0);
    check("rst_f_valid", {31'h0, f_valid}, 32'h0);
    check("rst_f_pc", f_pc, ResetPc);
    check("rst_f_instr", f_instr, 32'h0);
    @(negedge clk);
    #1 stray_ack = 1'b1;
    @(negedge clk);
    #1 stray_ack = 1'b0;
    expect_seq('{32'h3000, 32'h3004}, '{32'h3000, 32'h3004});
    reset     = 1'b1;
    stray_ack = 1'b1;
    #2;
    check("rst_boot_req", {31'h0, imem_bus.req}, 32'h0);
    @(negedge clk);
    #1 stray_ack = 1'b0;
    drain("reset_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
